// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86-64 pipeline: hazard detection,
// stall/bubble generation, RUN/DRAIN/HALT sequencing and hazard counters.
module pipe_ctrl #(
  parameter int          CNT_W = 32,
  parameter logic [3:0]  RNONE = 4'hF,
  parameter logic [3:0]  AOK   = 4'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic             cnt_clr,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] luse_cnt,
  output logic [CNT_W-1:0] misp_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_POPQ   = 4'd11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } state_t;

  state_t st;

  logic luse, misp, ret, mexc, wexc;

  assign luse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign misp = (E_icode == I_JXX) && !e_Cnd;
  assign ret  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mexc = (m_stat != AOK);
  assign wexc = (W_stat != AOK);

  assign state  = st;
  assign halted = (st == HALT);

  // Reset overrides everything so the pipeline registers flush while rst is high.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    if (!rst) begin
      case (st)
        RUN: begin
          F_stall  = luse || ret;
          D_stall  = luse;
          D_bubble = misp || (ret && !luse);
          E_bubble = misp || luse;
          M_bubble = mexc || wexc;
          W_stall  = wexc;
          set_cc   = (E_icode == I_OPQ) && !mexc && !wexc;
        end
        DRAIN: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          D_bubble = 1'b0;
          W_stall  = wexc;
        end
        default: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          D_bubble = 1'b0;
          W_stall  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= RUN;
    end else begin
      case (st)
        RUN: begin
          if (wexc)      st <= HALT;
          else if (mexc) st <= DRAIN;
        end
        DRAIN:   if (wexc) st <= HALT;
        HALT:    st <= HALT;
        default: st <= RUN;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      luse_cnt <= '0;
      misp_cnt <= '0;
      ret_cnt  <= '0;
      cyc_cnt  <= '0;
    end else if (cnt_clr) begin
      luse_cnt <= '0;
      misp_cnt <= '0;
      ret_cnt  <= '0;
      cyc_cnt  <= '0;
    end else if (st == RUN) begin
      cyc_cnt <= sat_inc(cyc_cnt);
      if (luse)         luse_cnt <= sat_inc(luse_cnt);
      if (misp)         misp_cnt <= sat_inc(misp_cnt);
      if (ret && !luse) ret_cnt  <= sat_inc(ret_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven combinational vectors plus
// directed sequences for counters, exceptions, reset and saturation.
module tb_pipe_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic e_Cnd, cnt_clr;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [1:0] state;
  logic [CNT_W-1:0] luse_cnt, misp_cnt, ret_cnt, cyc_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .cnt_clr(cnt_clr),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
    .state(state), .luse_cnt(luse_cnt), .misp_cnt(misp_cnt), .ret_cnt(ret_cnt),
    .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] di, sa, sb, ei, edm;
    logic       cnd;
    logic [3:0] mi, ms, ws;
    logic [6:0] exp;  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  } vec_t;

  vec_t vecs[15];

  function automatic logic [6:0] ctl();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    D_icode = 4'd1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'd1; E_dstM = 4'hF;
    e_Cnd = 1'b0; M_icode = 4'd1; m_stat = 4'd1; W_stat = 4'd1; cnt_clr = 1'b0;
  endtask

  task automatic edge_step();
    @(posedge clk); #1;
  endtask

  task automatic clear_cnt();
    @(negedge clk); cnt_clr = 1'b1;
    edge_step();
    cnt_clr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"nop",          1, 15, 15,  1, 15, 0, 1, 1, 1, 7'b0000000};
    vecs[1]  = '{"luse_srcA",    6,  3, 15,  5,  3, 0, 1, 1, 1, 7'b1101000};
    vecs[2]  = '{"luse_srcB",    6, 15,  3,  5,  3, 0, 1, 1, 1, 7'b1101000};
    vecs[3]  = '{"luse_popq",    6,  4, 15, 11,  4, 0, 1, 1, 1, 7'b1101000};
    vecs[4]  = '{"load_rnone",   6, 15, 15,  5, 15, 0, 1, 1, 1, 7'b0000000};
    vecs[5]  = '{"load_nodep",   6,  2,  4,  5,  3, 0, 1, 1, 1, 7'b0000000};
    vecs[6]  = '{"misp",         1, 15, 15,  7, 15, 0, 1, 1, 1, 7'b0011000};
    vecs[7]  = '{"jxx_taken",    1, 15, 15,  7, 15, 1, 1, 1, 1, 7'b0000000};
    vecs[8]  = '{"ret_in_D",     9, 15, 15,  1, 15, 0, 1, 1, 1, 7'b1010000};
    vecs[9]  = '{"luse_and_ret", 9,  3, 15,  5,  3, 0, 1, 1, 1, 7'b1101000};
    vecs[10] = '{"misp_and_ret", 9, 15, 15,  7, 15, 0, 1, 1, 1, 7'b1011000};
    vecs[11] = '{"opq_setcc",    1, 15, 15,  6, 15, 0, 1, 1, 1, 7'b0000001};
    vecs[12] = '{"opq_mexc",     1, 15, 15,  6, 15, 0, 1, 3, 1, 7'b0000100};
    vecs[13] = '{"opq_wexc",     1, 15, 15,  6, 15, 0, 1, 1, 2, 7'b0000110};
    vecs[14] = '{"ret_in_M",     1, 15, 15,  1, 15, 0, 9, 1, 1, 7'b1010000};

    idle();
    rst = 1'b1;
    #2;
    chk("reset_ctl", ctl(), 7'b0011100);
    chk("reset_state", state, 0);
    chk("reset_halted", halted, 0);
    chk("reset_cyc", cyc_cnt, 0);
    @(negedge clk); rst = 1'b0;

    // Vectors applied mid-cycle and withdrawn before the edge so state stays RUN.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      D_icode = vecs[i].di; d_srcA = vecs[i].sa; d_srcB = vecs[i].sb;
      E_icode = vecs[i].ei; E_dstM = vecs[i].edm; e_Cnd = vecs[i].cnd;
      M_icode = vecs[i].mi; m_stat = vecs[i].ms; W_stat = vecs[i].ws;
      #1;
      chk(vecs[i].name, ctl(), vecs[i].exp);
      #1 idle();
    end
    edge_step();
    chk("still_run", state, 0);

    // Load-use counter
    clear_cnt();
    @(negedge clk); E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3; D_icode = 4'd6;
    edge_step();
    chk("luse_cnt", luse_cnt, 1);
    chk("luse_ret_cnt", ret_cnt, 0);

    // Mispredict counter
    @(negedge clk); idle(); cnt_clr = 1'b1;
    edge_step();
    @(negedge clk); cnt_clr = 1'b0; E_icode = 4'd7; e_Cnd = 1'b0;
    #1 chk("misp_F_stall", F_stall, 0);
    edge_step();
    chk("misp_cnt", misp_cnt, 1);

    // Ret walk through D, E, M
    @(negedge clk); idle(); cnt_clr = 1'b1;
    edge_step();
    @(negedge clk); cnt_clr = 1'b0; D_icode = 4'd9;
    #1 chk("ret_walk_D", {F_stall, D_bubble}, 2'b11);
    edge_step();
    @(negedge clk); D_icode = 4'd1; E_icode = 4'd9;
    #1 chk("ret_walk_E", {F_stall, D_bubble}, 2'b11);
    edge_step();
    @(negedge clk); E_icode = 4'd1; M_icode = 4'd9;
    #1 chk("ret_walk_M", {F_stall, D_bubble}, 2'b11);
    edge_step();
    chk("ret_cnt", ret_cnt, 3);
    chk("cyc_cnt_3", cyc_cnt, 3);

    // Saturation and clear-over-increment
    @(negedge clk); idle(); cnt_clr = 1'b1;
    edge_step();
    @(negedge clk); cnt_clr = 1'b0; E_icode = 4'd7; e_Cnd = 1'b0;
    repeat (20) edge_step();
    chk("misp_sat", misp_cnt, 15);
    chk("cyc_sat", cyc_cnt, 15);
    @(negedge clk); cnt_clr = 1'b1;
    edge_step();
    chk("clr_over_inc", misp_cnt, 0);

    // Exception: DRAIN then HALT
    @(negedge clk); idle();
    edge_step();
    chk("cyc_after_clr", cyc_cnt, 1);
    @(negedge clk); E_icode = 4'd6; m_stat = 4'd3;
    #1 chk("mexc_ctl", {M_bubble, set_cc}, 2'b10);
    edge_step();
    chk("to_drain", state, 1);
    @(negedge clk); m_stat = 4'd1;
    #1 chk("drain_ctl", ctl(), 7'b1101100);
    repeat (2) edge_step();
    chk("drain_hold", state, 1);
    chk("drain_cyc_frozen", cyc_cnt, 2);
    @(negedge clk); W_stat = 4'd3;
    #1 chk("drain_wstall", W_stall, 1);
    edge_step();
    chk("to_halt", {state, halted}, 3'b101);
    @(negedge clk); W_stat = 4'd1; E_icode = 4'd1;
    repeat (3) edge_step();
    chk("halt_ctl", ctl(), 7'b1101110);
    chk("halt_absorb", state, 2);

    // Asynchronous reset mid-HALT
    #2 rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_cyc", cyc_cnt, 0);
    chk("arst_ctl", {D_bubble, halted}, 2'b10);
    @(negedge clk); rst = 1'b0;
    edge_step();
    chk("post_rst_run", {state, cyc_cnt}, {2'b00, 4'd1});
    #1 chk("post_rst_ctl", ctl(), 7'b0000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 pipeline. Sits beside decode/execute/memory.
- Detects load-use hazards, jXX mispredicts and ret. Drives stall/bubble to the F, D, E, M and W pipeline registers.
- Runs a RUN/DRAIN/HALT state machine on exceptional status codes.
- Keeps saturating hazard performance counters.

Parameters:
CNT_W, 32, width of each performance counter
RNONE, 4'hF, "no register" encoding
AOK, 4'd1, normal status code (HLT=2, ADR=3, INS=4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
D_icode  in  4  icode in D register
d_srcA  in  4  decode srcA
d_srcB  in  4  decode srcB
E_icode  in  4  icode in E register
E_dstM  in  4  dstM in E register
e_Cnd  in  1  execute condition result
M_icode  in  4  icode in M register
m_stat  in  4  status leaving memory stage
W_stat  in  4  status in W register
cnt_clr  in  1  synchronous clear of all counters
F_stall  out  1  hold F register
D_stall  out  1  hold D register
D_bubble  out  1  load nop into D
E_bubble  out  1  load nop into E
M_bubble  out  1  load nop into M
W_stall  out  1  hold W register
set_cc  out  1  permit condition-code write
halted  out  1  state == HALT
state  out  2  00 RUN, 01 DRAIN, 10 HALT
luse_cnt  out  CNT_W  load-use stall cycles
misp_cnt  out  CNT_W  mispredict flushes
ret_cnt  out  CNT_W  ret bubble cycles
cyc_cnt  out  CNT_W  cycles spent in RUN

Behaviour:
- Hazard terms (combinational):
  - luse = (E_icode==5 || E_icode==11) && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
  - misp = E_icode==7 && !e_Cnd.
  - ret = D_icode==9 || E_icode==9 || M_icode==9.
  - mexc = m_stat!=AOK.
  - wexc = W_stat!=AOK.
- Outputs in RUN (combinational from inputs and state):
  - F_stall = luse || ret.
  - D_stall = luse.
  - D_bubble = misp || (ret && !luse).
  - E_bubble = misp || luse.
  - M_bubble = mexc || wexc.
  - W_stall = wexc.
  - set_cc = E_icode==6 && !mexc && !wexc.
- DRAIN outputs: F_stall=1, D_stall=1, D_bubble=0, E_bubble=1, M_bubble=1, set_cc=0, W_stall=wexc.
- HALT outputs: F_stall=1, D_stall=1, D_bubble=0, E_bubble=1, M_bubble=1, W_stall=1, set_cc=0, halted=1.
- State transitions (registered, rising clk):
  - RUN -> HALT if wexc (takes priority over mexc).
  - RUN -> DRAIN if mexc && !wexc.
  - DRAIN -> HALT if wexc; otherwise stay in DRAIN.
  - HALT is absorbing; only rst leaves it.
- Reset (async, immediate, while rst=1):
  - state=RUN; all counters 0.
  - Control outputs forced to F_stall=0, D_stall=0, D_bubble=1, E_bubble=1, M_bubble=1, W_stall=0, set_cc=0, halted=0, so the pipeline flushes during reset.
  - Reset asserted mid-DRAIN or mid-HALT returns to RUN on the same edge as rst rises, with no clk needed.
- Counters (registered, RUN only):
  - cyc_cnt +1 every RUN cycle.
  - luse_cnt +1 per cycle with luse.
  - misp_cnt +1 per cycle with misp.
  - ret_cnt +1 per cycle with ret && !luse.
  - Each counter saturates at 2^CNT_W-1; no wrap.
  - cnt_clr=1 zeroes all counters at the next edge and overrides any increment in that cycle.
  - Counters freeze in DRAIN and HALT.
- Simultaneous luse && ret: stall D, bubble E, no D bubble; ret_cnt does not increment.
- Simultaneous misp && ret (ret in D behind a mispredicted jXX): D_bubble=1, E_bubble=1, F_stall=1.
- Latency: control outputs have zero latency from inputs; state and counters have one-cycle latency.

Test Plan:
1. Load-use: E_icode=5, E_dstM=3, d_srcA=3, D_icode=6 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; luse_cnt 0->1 after one edge.
2. Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; misp_cnt increments. With e_Cnd=1 -> all controls 0.
3. Ret walk: D_icode=9 for 1 cycle, then E_icode=9, then M_icode=9 -> F_stall=1, D_bubble=1 for 3 consecutive cycles; ret_cnt=3.
4. Exception: m_stat=3 for one cycle -> M_bubble=1, set_cc=0, state=DRAIN next edge. Then W_stat=3 -> state=HALT, halted=1, W_stall=1 permanently.
5. Reset mid-HALT: assert rst between clock edges -> state=00 and counters=0 immediately; D_bubble=1 while rst=1; normal RUN after release.
6. Saturation and clear: CNT_W=4, hold misp 20 cycles -> misp_cnt stays at 15. Pulse cnt_clr with misp=1 -> misp_cnt=0 next edge.
